// File: rtl/mips_cpu_ctrl_pkg.sv
// mips_cpu_ctrl_pkg: shared state encoding and halt address for the multicycle sequencer
package mips_cpu_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} ctrl_state_t;
    localparam logic [31:0] HALT_ADDR = 32'h0000_0000;
endpackage

// File: rtl/mips_wait_watchdog.sv
// mips_wait_watchdog: counts consecutive waitrequest cycles of one memory access
//   clk, reset (sync, active-low) ; clear: restart count ; stall: waitrequest seen
//   timeout: stall persists after MAX_WAIT counted stall cycles
module mips_wait_watchdog import mips_cpu_ctrl_pkg::*; #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic timeout
);
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
    logic [WAIT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (!reset || clear) cnt <= '0;
        else if (stall && cnt != LIMIT) cnt <= cnt + 1'b1;
    // exactly MAX_WAIT stall cycles are tolerated; the next one still stalled trips
    assign timeout = stall && cnt == LIMIT;
endmodule

// File: rtl/mips_cpu_seq_ctrl.sv
// mips_cpu_seq_ctrl: multicycle fetch/exec/mem sequencer with single-commit gating
//   clk, reset (sync, active-low)
//   instr_read/instr_waitrequest : instruction memory handshake
//   mem_read/mem_write           : decoded load/store of current instruction
//   data_read/data_write/data_waitrequest : data memory handshake
//   branch_taken/target_address  : redirect info, used to detect jump-to-0 halt
//   regwrite_in -> regwrite      : register write gated by commit
//   clk_enable : commit pulse ; active : running ; fault : sticky error
//   instr_count : committed instructions
module mips_cpu_seq_ctrl import mips_cpu_ctrl_pkg::*; #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        data_read,
    output logic        data_write,
    input  logic        data_waitrequest,
    input  logic        branch_taken,
    input  logic [31:0] target_address,
    input  logic        regwrite_in,
    output logic        regwrite,
    output logic        clk_enable,
    output logic        active,
    output logic        fault,
    output logic [31:0] instr_count
);
    ctrl_state_t state, next_state;
    logic halt_pending, commit, illegal, stall, timeout, wd_clear;
    always_comb begin
        illegal = state == S_EXEC && mem_read && mem_write;
        // gated by reset so an access accepted during the reset cycle never commits
        commit = reset && ((state == S_EXEC && !mem_read && !mem_write) ||
                           (state == S_MEM && !data_waitrequest));
        stall = (state == S_FETCH && instr_waitrequest) || (state == S_MEM && data_waitrequest);
        case (state)
            S_IDLE:  next_state = S_FETCH;
            S_FETCH: next_state = timeout ? S_HALT : instr_waitrequest ? S_FETCH : S_EXEC;
            S_EXEC:  next_state = illegal ? S_HALT : (mem_read || mem_write) ? S_MEM :
                                  halt_pending ? S_HALT : S_FETCH;
            S_MEM:   next_state = timeout ? S_HALT : data_waitrequest ? S_MEM :
                                  halt_pending ? S_HALT : S_FETCH;
            default: next_state = S_HALT;
        endcase
        wd_clear = next_state != state && (next_state == S_FETCH || next_state == S_MEM);
    end
    mips_wait_watchdog #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wd (
        .clk(clk), .reset(reset), .clear(wd_clear), .stall(stall), .timeout(timeout)
    );
    always_ff @(posedge clk)
        if (!reset) begin
            state        <= S_IDLE;
            halt_pending <= 1'b0;
            fault        <= 1'b0;
            instr_count  <= '0;
            data_read    <= 1'b0;
            data_write   <= 1'b0;
        end else begin
            state <= next_state;
            fault <= fault | illegal | timeout;
            if (commit) begin
                instr_count  <= instr_count + 32'd1;
                // a pending halt wins: the delay slot just committed, even if it jumps to 0 itself
                halt_pending <= !halt_pending && branch_taken && target_address == HALT_ADDR;
            end
            // requests latch on entry to S_MEM and stay frozen until the access is accepted
            data_read  <= next_state == S_MEM && (state == S_MEM ? data_read : mem_read);
            data_write <= next_state == S_MEM && (state == S_MEM ? data_write : mem_write);
        end
    assign instr_read = state == S_FETCH;
    assign active     = state == S_FETCH || state == S_EXEC || state == S_MEM;
    assign clk_enable = commit;
    assign regwrite   = regwrite_in & commit;
endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// tb_mips_cpu_seq_ctrl: directed scoreboard bench for the multicycle sequencer
module tb_mips_cpu_seq_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        instr_read, instr_waitrequest = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        data_read, data_write, data_waitrequest = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] target_address = '0;
    logic        regwrite_in = 1'b0, regwrite, clk_enable, active, fault;
    logic [31:0] instr_count;
    int          errors = 0, checks = 0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_count = '0;

    always #5 clk = ~clk;

    mips_cpu_seq_ctrl #(.MAX_WAIT(8), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .instr_read(instr_read), .instr_waitrequest(instr_waitrequest),
        .mem_read(mem_read), .mem_write(mem_write), .data_read(data_read), .data_write(data_write),
        .data_waitrequest(data_waitrequest), .branch_taken(branch_taken),
        .target_address(target_address), .regwrite_in(regwrite_in), .regwrite(regwrite),
        .clk_enable(clk_enable), .active(active), .fault(fault), .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // every commit pulse must match the oldest outstanding instruction: {regwrite, count before increment}
    always @(negedge clk)
        if (clk_enable !== 1'b0) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL commit_unexpected: observed pulse at count=%0d expected=none", instr_count);
            end
            if (exp_q.size() > 0) check("commit", {regwrite, instr_count}, exp_q.pop_front());
        end

    // called during a FETCH cycle; returns during the cycle after the commit
    task automatic run(input logic mr, mw, rw, bt, input logic [31:0] tgt, input int iw, dw);
        exp_q.push_back({rw, exp_count});
        exp_count++;
        mem_read = mr; mem_write = mw; regwrite_in = rw;
        branch_taken = bt; target_address = tgt;
        instr_waitrequest = iw > 0;
        data_waitrequest = dw > 0;
        repeat (iw) step;
        instr_waitrequest = 1'b0;
        step;
        if (mr | mw) begin
            step;
            for (int i = 0; i <= dw; i++) begin
                if (i == dw) data_waitrequest = 1'b0;
                @(negedge clk);
                check("mem_cycle", {29'b0, data_read, data_write, clk_enable, regwrite},
                      {29'b0, mr, mw, i == dw, i == dw && rw});
                step;
            end
        end else step;
        mem_read = 1'b0; mem_write = 1'b0; regwrite_in = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; regwrite_in = 1'b0; branch_taken = 1'b0;
        instr_waitrequest = 1'b0; data_waitrequest = 1'b0;
        step;
        @(negedge clk);
        check("reset_flags", {27'b0, active, fault, instr_read, data_read, data_write, clk_enable}, 33'd0);
        check("reset_count", {1'b0, instr_count}, 33'd0);
        reset = 1'b1;
        exp_count = '0;
        step;
        @(negedge clk);
        check("fetch_start", {31'b0, active, instr_read}, 33'd3);
    endtask

    initial begin
        step;
        do_reset;
        for (int k = 0; k < 3; k++) run(0, 0, 1, 0, 32'h0, 0, 0);
        @(negedge clk);
        check("alu_count", {1'b0, instr_count}, 33'd3);
        run(1, 0, 1, 0, 32'h0, 0, 4);
        run(0, 1, 0, 0, 32'h0, 3, 0);
        run(1, 0, 1, 0, 32'h0, 0, 8);
        run(0, 0, 1, 0, 32'h0, 8, 0);
        @(negedge clk);
        check("legal_stalls", {fault, instr_count}, {1'b0, 32'd7});
        run(0, 0, 1, 1, 32'h40, 0, 0);
        run(0, 0, 1, 1, 32'h0, 0, 0);
        run(0, 0, 1, 0, 32'h0, 0, 0);
        @(negedge clk);
        check("halt_state", {fault, active, instr_read, instr_count[29:0]}, {3'b000, 30'd10});
        repeat (3) step;
        @(negedge clk);
        check("halt_stays", {30'b0, active, instr_read, clk_enable}, 33'd0);

        do_reset;
        instr_waitrequest = 1'b1;
        repeat (8) step;
        @(negedge clk);
        check("stall_8_ok", {30'b0, fault, active, instr_read}, 33'd3);
        step;
        @(negedge clk);
        check("stall_timeout", {30'b0, fault, active, instr_read}, 33'd4);

        do_reset;
        run(0, 0, 1, 0, 32'h0, 0, 0);
        mem_read = 1'b1; mem_write = 1'b1; regwrite_in = 1'b1;
        step;
        @(negedge clk);
        check("illegal_exec", {31'b0, clk_enable, regwrite}, 33'd0);
        step;
        @(negedge clk);
        check("illegal_halt", {28'b0, fault, active, instr_read, data_read, data_write}, 33'h10);
        do_reset;

        run(0, 0, 1, 0, 32'h0, 0, 0);
        mem_write = 1'b1; data_waitrequest = 1'b1;
        step;
        step;
        @(negedge clk);
        check("store_req", {31'b0, data_write, clk_enable}, 33'd2);
        step;
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_mem", {32'b0, clk_enable}, 33'd0);
        step;
        @(negedge clk);
        check("store_dropped", {data_write, instr_count}, 33'd0);
        do_reset;

        run(0, 0, 1, 1, 32'h0, 0, 0);
        run(0, 0, 0, 1, 32'h0, 0, 0);
        step;
        @(negedge clk);
        check("ds_jump_halt", {active, instr_count}, {1'b0, 32'd2});
        check("queue_drained", 33'(exp_q.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
